// File: rtl/padds_pipe_if.sv
// Handshake and data bundle for the packed saturating add/sub unit.
// Lane i of in1/in2/out occupies bits [i*LANE_W +: LANE_W].
interface padds_pipe_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES-1:0][LANE_W-1:0]  in1;
  logic [LANES-1:0][LANE_W-1:0]  in2;
  logic                          op_sub;
  logic                          op_unsigned;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES-1:0][LANE_W-1:0]  out;
  logic [LANES-1:0]              sat_lane;
  logic                          sat_sticky;
  logic                          sat_clr;

  modport master (
    output in_valid, in1, in2, op_sub, op_unsigned, out_ready, sat_clr,
    input  in_ready, out_valid, out, sat_lane, sat_sticky
  );

  modport slave (
    input  in_valid, in1, in2, op_sub, op_unsigned, out_ready, sat_clr,
    output in_ready, out_valid, out, sat_lane, sat_sticky
  );
endinterface

// File: rtl/padds_pipe.sv
// Elastic pipelined packed saturating add/sub, 1 or 2 stages.
// Optional sticky saturation flag enabled by defining PADDS_STICKY_EN.

// Clamps one (LANE_W+1)-bit extended lane result to LANE_W bits.
module padds_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W:0]   r,
  input  logic              sub,
  input  logic              uns,
  output logic [LANE_W-1:0] res,
  output logic              sat
);
  always_comb begin
    res = r[LANE_W-1:0];
    sat = 1'b0;
    if (uns) begin
      if (r[LANE_W]) begin
        sat = 1'b1;
        res = sub ? '0 : '1;
      end
    end else if (r[LANE_W] ^ r[LANE_W-1]) begin
      // top bit of the extended result tells which way we overflowed
      sat = 1'b1;
      res = {r[LANE_W], {(LANE_W-1){~r[LANE_W]}}};
    end
  end
endmodule

module padds_pipe #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  padds_pipe_if.slave   bus
);
  localparam int EW = LANE_W + 1;
  typedef logic [LANES-1:0][EW-1:0] ext_t;

  logic [STAGES:1]             vld_q;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1]             rdy_pipe;
  ext_t                        a_x, b_x, r_in, r_s;
  logic                        sub_s, uns_s;
  logic [LANES-1:0][LANE_W-1:0] res_c, res_q;
  logic [LANES-1:0]            sat_c, sat_q;

  assign vld_pipe = {vld_q, bus.in_valid};

  // ready ripples back from the output: a stage can load if empty or draining
  always_comb begin
    logic nxt;
    nxt      = bus.out_ready;
    rdy_pipe = '0;
    for (int k = STAGES; k >= 1; k--) begin
      rdy_pipe[k] = !vld_pipe[k] | nxt;
      nxt         = rdy_pipe[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else
      for (int k = 1; k <= STAGES; k++)
        if (rdy_pipe[k]) vld_q[k] <= vld_pipe[k-1];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_ext
    assign a_x[l]  = bus.op_unsigned ? {1'b0, bus.in1[l]} : {bus.in1[l][LANE_W-1], bus.in1[l]};
    assign b_x[l]  = bus.op_unsigned ? {1'b0, bus.in2[l]} : {bus.in2[l][LANE_W-1], bus.in2[l]};
    assign r_in[l] = bus.op_sub ? a_x[l] - b_x[l] : a_x[l] + b_x[l];
  end

  if (STAGES == 2) begin : g_s2
    ext_t r_q;
    logic sub_q, uns_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q   <= '0;
        sub_q <= 1'b0;
        uns_q <= 1'b0;
      end else if (rdy_pipe[1] && vld_pipe[0]) begin
        r_q   <= r_in;
        sub_q <= bus.op_sub;
        uns_q <= bus.op_unsigned;
      end
    end
    assign r_s   = r_q;
    assign sub_s = sub_q;
    assign uns_s = uns_q;
  end else begin : g_s1
    assign r_s   = r_in;
    assign sub_s = bus.op_sub;
    assign uns_s = bus.op_unsigned;
  end

  padds_lane #(.LANE_W(LANE_W)) u_lane [LANES-1:0] (
    .r   (r_s),
    .sub (sub_s),
    .uns (uns_s),
    .res (res_c),
    .sat (sat_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      sat_q <= '0;
    end else if (rdy_pipe[STAGES] && vld_pipe[STAGES-1]) begin
      res_q <= res_c;
      sat_q <= sat_c;
    end
  end

  assign bus.in_ready  = rdy_pipe[1];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out       = res_q;
  assign bus.sat_lane  = sat_q;

`ifdef PADDS_STICKY_EN
  logic sticky_q;
  // set takes priority over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else if (bus.out_valid && bus.out_ready && |sat_q) sticky_q <= 1'b1;
    else if (bus.sat_clr) sticky_q <= 1'b0;
  end
  assign bus.sat_sticky = sticky_q;
`else
  logic sat_clr_unused;
  assign sat_clr_unused = bus.sat_clr;
  assign bus.sat_sticky = 1'b0;
`endif
endmodule
